pri_arb8_ctrl: RTL and testbench
================================

Name: pri_arb8_ctrl

Overview:
- Sequential 8-requester arbiter built around 8:3 priority-encode logic. Shares one downstream resource between 8 requesters.
- Latches a winner and holds the grant until the owner releases it or a hold timeout fires.
- Outputs both a one-hot grant and an encoded index/valid pair, in the same form as the team's 8:3 priority encoder outputs.
- Default policy is fixed priority, where bit 7 is highest. Rotating priority is an optional build feature.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; index width is 3.
- MAX_HOLD, 16, maximum cycles a grant may be held. 0 disables the timeout. Legal range is 0..255.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  8  request vector. req[i]=1 means requester i wants the resource.
- done  in  1  owner release pulse; sampled only in BUSY.
- gnt  out  8  one-hot grant; all zero when no grant.
- gnt_idx  out  3  encoded index of the current owner; 0 when gnt_valid=0.
- gnt_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge), regardless of state:
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hold_cnt=0, last_idx=0.
  - Reset mid-grant drops the grant on that same edge.
- States: IDLE, BUSY.
- IDLE:
  - If req!=0, select the winner (highest set index in fixed mode) and go to BUSY.
  - At the next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, hold_cnt=0, last_idx=w.
  - If req=0, stay in IDLE with outputs at zero.
- Latency: req sampled at edge N produces gnt visible after edge N+1 (1 cycle).
- BUSY:
  - gnt and gnt_idx are frozen. Changes to other req bits, including higher-priority ones, are ignored (no preemption).
  - hold_cnt increments every cycle, saturating at 255.
- Release from BUSY. Check these in priority order at each edge:
  - (a) done=1, or (b) req[gnt_idx]=0: go to IDLE with gnt=0, gnt_valid=0, gnt_idx=0, timeout=0.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: go to IDLE with gnt cleared and timeout=1 for exactly one cycle.
  - If done and timeout coincide, done wins and timeout stays 0.
- Dead cycle: after any release, IDLE always lasts at least one cycle with gnt=0. Back-to-back grants are therefore separated by exactly one idle cycle.
- Grant ownership: the owner is granted for at most MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts one cycle, followed by the timeout pulse.
- done while IDLE is ignored.
- gnt is never multi-hot, and gnt_valid == |gnt at all times.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - The search starts at index (last_idx-1) mod 8 and proceeds downward with wrap: last_idx-1, last_idx-2, … , last_idx.
  - The first set bit found wins.
  - After reset, last_idx=0, so the search starts at 7. The first arbitration therefore matches fixed priority.
  - A single persistent requester still wins repeatedly.
- Undefined: fixed priority, highest set index wins. last_idx is still updated but does not affect selection.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, req=8'hFF → gnt=0, gnt_idx=0, gnt_valid=0, timeout=0. Release reset with req=0 → outputs stay 0.
- Fixed select + latency: req=8'b10101000 at edge N → after N+1, gnt=8'h80, gnt_idx=7, gnt_valid=1. Then req=8'b01001000 with req[7] dropped → next edge gnt=0; following edge gnt=8'h40, gnt_idx=6.
- No preemption / done release: owner idx=1 (req=8'b00000010) granted; raise req[7] → gnt stays 8'h02. Pulse done → one idle cycle, then gnt=8'h80, gnt_idx=7.
- Timeout: MAX_HOLD=4, req=8'b00000001 held high → gnt_valid high for 4 cycles, then timeout=1 for 1 cycle with gnt=0. Regranted to idx 0 the following cycle; the pattern repeats every 5 cycles.
- Reset mid-grant: during BUSY with gnt=8'h08, assert rst_n=0 for 1 cycle → gnt=0 at that edge. After release with req=8'h08 held → regrant 1 cycle later.
- Round robin (ARB_ROUND_ROBIN_EN): req=8'hFF held, each grant released by done → grant order idx 7,6,5,…,0,7. Without the macro, idx 7 is granted every time.

Source files
------------

// File: rtl/pri_arb8_ctrl.sv
// Sequential 8-requester arbiter: latches a winner and holds it until release or hold timeout.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority (default is fixed, bit 7 highest).
module pri_arb8_ctrl #(
    parameter int unsigned N_REQ    = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam bit          TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_EN ? MAX_HOLD - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [IDX_W-1:0]   gnt_idx_d;
    logic               gnt_valid_d;
    logic               timeout_d;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_d;
    logic [IDX_W-1:0]   last_idx, last_idx_d;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   cand;
`endif

    // Winner selection; later loop iterations override earlier ones, so they carry higher priority.
    always_comb begin
        win_idx   = '0;
        win_found = |req;
`ifdef ARB_ROUND_ROBIN_EN
        cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'(last_idx - IDX_W'(k));
            if (req[cand]) win_idx = cand;
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) win_idx = IDX_W'(i);
        end
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        gnt_d       = gnt;
        gnt_idx_d   = gnt_idx;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt;
        last_idx_d  = last_idx;
        case (state)
            IDLE: begin
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
                if (win_found) begin
                    state_d     = BUSY;
                    gnt_d       = N_REQ'(1) << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    last_idx_d  = win_idx;
                end
            end
            BUSY: begin
                if (done || !req[gnt_idx]) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST)) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    timeout_d   = 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_cnt_d = CNT_W'(hold_cnt + 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last_idx  <= '0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            gnt_idx   <= gnt_idx_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
            hold_cnt  <= hold_cnt_d;
            last_idx  <= last_idx_d;
        end
    end

endmodule

// File: tb/tb_pri_arb8_ctrl.sv
// Scoreboard bench for pri_arb8_ctrl: a reference model predicts the outputs after each edge,
// and a negedge monitor pops and compares them against the DUT.
module tb_pri_arb8_ctrl;

    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: owner = -1 when nobody holds the resource; held = cycles the grant has been visible.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    pri_arb8_ctrl #(.N_REQ(8), .MAX_HOLD(MAX_HOLD)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int last);
        int w;
        w = -1;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            if (w < 0 && r[(last - k + 8) % 8]) w = (last - k + 8) % 8;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (w < 0 && r[i]) w = i;
        end
`endif
        return w;
    endfunction

    task automatic model_edge(input logic rn, input logic [7:0] r, input logic d);
        int w;
        if (!rn) begin
            m_owner = -1; m_held = 0; m_last = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            w = pick(r, m_last);
            if (w >= 0) begin
                m_owner = w; m_held = 1; m_last = w;
            end
        end else if (d || !r[m_owner]) begin
            m_owner = -1; m_to = 1'b0;
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            m_owner = -1; m_to = 1'b1;
        end else begin
            m_held++; m_to = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, then predict the outputs after the edge.
    task automatic step(input logic rn, input logic [7:0] r, input logic d);
        exp_t e;
        rst_n = rn; req = r; done = d;
        @(posedge clk);
        model_edge(rn, r, d);
        e.gnt   = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e.idx   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e.valid = (m_owner >= 0);
        e.to    = m_to;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic hold(input logic [7:0] r, input int n);
        for (int i = 0; i < n; i++) step(1'b1, r, 1'b0);
    endtask

    // Monitor: every edge presents a fresh output set; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || timeout !== e.to) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got gnt=%h idx=%0d valid=%b to=%b want gnt=%h idx=%0d valid=%b to=%b",
                             cyc, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.valid, e.to);
                end
            end
        end
    end

    initial begin
        // Reset with all requests asserted, then release with no requests.
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        hold(8'h00, 2);
        // Fixed select and latency, then re-arbitration after the owner drops.
        hold(8'b1010_1000, 2);
        hold(8'b0100_1000, 3);
        hold(8'h00, 2);
        // No preemption; done releases into one dead cycle.
        hold(8'b0000_0010, 2);
        hold(8'b1000_0010, 2);
        step(1'b1, 8'b1000_0010, 1'b1);
        hold(8'b1000_0010, 3);
        hold(8'h00, 2);
        // Timeout cadence with a persistent single requester.
        hold(8'b0000_0001, 16);
        // done coinciding with timeout: done wins.
        hold(8'h00, 2);
        hold(8'h01, MAX_HOLD);
        step(1'b1, 8'h01, 1'b1);
        hold(8'h00, 2);
        // done in IDLE is ignored.
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        // Reset mid-grant, then regrant.
        hold(8'h08, 2);
        step(1'b0, 8'h08, 1'b0);
        hold(8'h08, 3);
        hold(8'h00, 2);
        // Saturated request vector released by done each grant.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            step(1'b1, 8'hFF, 1'b1);
        end
        hold(8'h00, 2);
        // Randomized traffic with occasional reset.
        begin
            logic [7:0] r;
            logic       d;
            logic       rn;
            r = 8'h00;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(3) == 0) r = 8'($urandom);
                d  = ($urandom_range(7) == 0);
                rn = ($urandom_range(99) != 0);
                step(rn, r, d);
            end
        end
        step(1'b1, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
